sha2_nonce_sequencer: RTL and testbench
=======================================

// Module: sha2_nonce_sequencer
// PURPOSE
// - Upstream controller for one sha2_chunk core; sweeps a nonce range doing Bitcoin double SHA-256 per nonce.
// - Per nonce: pass 1 hashes header chunk 2 from the supplied midstate; pass 2 hashes that 256-bit digest from IV.
// - Compares each final digest against a target and reports the first hit, or reports range exhausted.
// PARAMETERS
// - NONCE_W  32  nonce / count width; fixed at 32, present only for package consistency
// PORTS
// - clk           in   1    system clock
// - reset         in   1    asynchronous, active-high reset
// - cmd_valid     in   1    job request
// - cmd_ready     out  1    high only in IDLE
// - midstate      in   256  SHA state after header chunk 1; h0 in [255:224]
// - tail          in   96   header bytes 64..75 (merkle tail, time, bits); word0 in [95:64]
// - nonce_start   in   32   first nonce tried
// - nonce_count   in   32   nonces to try; 0 means 2^32
// - target        in   256  hit if hash value <= target
// - abort         in   1    cancel running job
// - res_valid     out  1    result available
// - res_ready     in   1    result accepted
// - res_found     out  1    1 = hit, 0 = exhausted or aborted
// - res_nonce     out  32   hit nonce, else last nonce tried
// - res_hash      out  256  byte-reversed final digest of res_nonce
// - core_reset    out  1    to sha2_chunk.reset
// - core_start    out  1    to sha2_chunk.start
// - core_chunk    out  512  to sha2_chunk.chunk; word0 in [511:480]
// - core_h        out  256  to sha2_chunk h0..h7; h0 in [255:224]
// - core_h_out    in   256  from sha2_chunk h0_out..h7_out; h0 in [255:224]
// - core_done     in   1    from sha2_chunk.done
// BEHAVIOUR
// - Reset values: cmd_ready=1, res_valid=0, res_found=0, res_nonce=0, res_hash=0, core_start=0, core_reset=1.
// - core_reset stays 1 for the first clk after reset deasserts and for 1 cycle on abort; otherwise 0.
// - States: IDLE, P1_RUN, P1_GAP, P2_RUN, P2_GAP, CHECK, REPORT, ABORT.
// - IDLE -> P1_RUN on cmd_valid & cmd_ready.
//   - Latch all cmd inputs; cur_nonce=nonce_start; remaining=nonce_count (33-bit; 0 loads 2^32).
// - P1_RUN: core_start=1.
//   - core_h=midstate.
//   - core_chunk = {tail, bswap32(cur_nonce), 32'h80000000, 10x32'h0, 32'h00000280}.
//   - On core_done: latch core_h_out into d1, go to P1_GAP.
// - P1_GAP: core_start=0 for exactly 1 cycle so the core clears done and re-arms; then P2_RUN.
// - P2_RUN: core_start=1.
//   - core_h=SHA256_IV.
//   - core_chunk = {d1, 32'h80000000, 6x32'h0, 32'h00000100}.
//   - On core_done: latch digest d2, go to P2_GAP.
// - P2_GAP: 1 cycle with core_start=0, then CHECK.
// - CHECK, 1 cycle: hv = byte-reverse of all 32 bytes of d2; hit = (hv <= target), unsigned 256-bit compare.
//   - hit or remaining==1: load res_*, go to REPORT.
//   - Otherwise: cur_nonce += 1 (mod 2^32; 0xFFFFFFFF wraps to 0), remaining -= 1, go to P1_RUN.
// - REPORT: res_valid=1; res_* held stable until res_ready; then IDLE.
// - Throughput: 2 x (core latency + 1 gap cycle) + 1 cycle per nonce. core_done is waited on, never counted.
// - abort is sampled in P1_RUN, P1_GAP, P2_RUN, P2_GAP and CHECK; it wins over every transition in the same cycle.
//   - Go to ABORT: core_start=0, core_reset=1.
//   - Next cycle, REPORT with res_found=0, res_nonce=cur_nonce, res_hash=0.
// - abort in IDLE or REPORT is ignored.
// - core_done seen in any non-RUN state is ignored.
// - Async reset mid-job: everything returns to reset values immediately; no result is produced.
// STRUCTURE
// - Package sha2_pkg: SHA256_IV[0:7], PAD_WORD=32'h80000000, LEN_HDR=32'h280, LEN_DIG=32'h100, state enum, bswap32().
// - Sub-module sha2_target_cmp: combinational byte-reverse plus 256-bit <= compare, registered in CHECK.
// - sha2_chunk is instantiated by the parent, not inside this block.
// TESTING
// - Bench pairs this block with a real sha2_chunk.
// - Genesis header: midstate and tail from block 0, nonce_start=32'h7C2BAC1D, count=1, target=32'hFFFF<<208.
//   - Expect res_found=1, res_nonce=7C2BAC1D, res_hash=000000000019d668...e26f.
// - Same header, nonce_start=32'h7C2BAC1B, count=4.
//   - Expect 3 passes pairs, then found at 7C2BAC1D; cmd_ready low throughout.
// - nonce_start=32'hFFFFFFFF, count=2, target=0.
//   - Expect res_found=0, res_nonce=0, and wrap with no X.
// - abort pulsed during P2_RUN of nonce 5.
//   - Expect core_reset 1-cycle pulse, then res_valid with found=0, res_nonce=5.
//   - Then a new cmd is accepted and produces correct results.
// - Hold res_ready=0 for 20 cycles after the hit.
//   - Expect res_* stable, core_start=0, no new cmd accepted.
// - Assert async reset mid-P1_RUN.
//   - Expect outputs at reset values before the next clk edge, and core_reset=1.

Source files
------------

// File: rtl/sha2_pkg.sv
// Shared constants, state codes and helpers for the
// double SHA-256 nonce sequencer.
package sha2_pkg;

  localparam int NONCE_W = 32;

  localparam logic [31:0] SHA256_IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] PAD_WORD = 32'h80000000;
  localparam logic [31:0] LEN_HDR  = 32'h00000280;
  localparam logic [31:0] LEN_DIG  = 32'h00000100;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t ST_IDLE   = 3'd0;
  localparam seq_state_t ST_P1_RUN = 3'd1;
  localparam seq_state_t ST_P1_GAP = 3'd2;
  localparam seq_state_t ST_P2_RUN = 3'd3;
  localparam seq_state_t ST_P2_GAP = 3'd4;
  localparam seq_state_t ST_CHECK  = 3'd5;
  localparam seq_state_t ST_REPORT = 3'd6;
  localparam seq_state_t ST_ABORT  = 3'd7;

  function automatic logic [31:0] bswap32(
    input logic [31:0] w
  );
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // IV packed with h0 in the top word
  function automatic logic [255:0] iv_vec();
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 8; i++)
      v[255-32*i -: 32] = SHA256_IV[i];
    return v;
  endfunction

endpackage

// File: rtl/sha2_target_cmp.sv
// Byte-reverses a SHA-256 digest into a hash value and compares
// it (unsigned) against a target. Ports: digest, target in; hv, hit out.
module sha2_target_cmp
  import sha2_pkg::*;
(
  input  logic [255:0] digest,
  input  logic [255:0] target,
  output logic [255:0] hv,
  output logic         hit
);

  // digest byte 0 (top) lands in hv byte 0 (bottom)
  always_comb begin
    hv = '0;
    for (int i = 0; i < 32; i++)
      hv[8*i +: 8] = digest[255-8*i -: 8];
  end

  assign hit = (hv <= target);

endmodule

// File: rtl/sha2_nonce_sequencer.sv
// Drives one sha2_chunk core through a nonce range, two passes per nonce.
// Ports: cmd_* job in, res_* result out, core_* to/from the core.
module sha2_nonce_sequencer
  import sha2_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [255:0] midstate,
  input  logic [95:0]  tail,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_count,
  input  logic [255:0] target,
  input  logic         abort,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         res_found,
  output logic [31:0]  res_nonce,
  output logic [255:0] res_hash,
  output logic         core_reset,
  output logic         core_start,
  output logic [511:0] core_chunk,
  output logic [255:0] core_h,
  input  logic [255:0] core_h_out,
  input  logic         core_done
);

  seq_state_t           state;
  logic [255:0]         mid_q;
  logic [95:0]          tail_q;
  logic [255:0]         target_q;
  logic [NONCE_W-1:0]   cur_nonce;
  logic [NONCE_W:0]     remaining;
  logic [255:0]         d1;
  logic [255:0]         d2;
  logic [255:0]         hv;
  logic                 hit;
  logic                 active;
  logic [511:0]         p1_chunk;
  logic [511:0]         p2_chunk;

  sha2_target_cmp u_cmp (
    .digest (d2),
    .target (target_q),
    .hv     (hv),
    .hit    (hit)
  );

  assign cmd_ready  = (state == ST_IDLE);
  assign res_valid  = (state == ST_REPORT);
  assign core_start = (state == ST_P1_RUN) ||
                      (state == ST_P2_RUN);

  assign active = (state == ST_P1_RUN) ||
                  (state == ST_P1_GAP) ||
                  (state == ST_P2_RUN) ||
                  (state == ST_P2_GAP) ||
                  (state == ST_CHECK);

  assign p1_chunk = {tail_q, bswap32(cur_nonce),
                     PAD_WORD, 320'h0, LEN_HDR};
  assign p2_chunk = {d1, PAD_WORD, 192'h0, LEN_DIG};

  assign core_chunk = (state == ST_P2_RUN) ?
                      p2_chunk : p1_chunk;
  assign core_h     = (state == ST_P2_RUN) ?
                      iv_vec() : mid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      core_reset <= 1'b1;
      res_found  <= 1'b0;
      res_nonce  <= '0;
      res_hash   <= '0;
      mid_q      <= '0;
      tail_q     <= '0;
      target_q   <= '0;
      cur_nonce  <= '0;
      remaining  <= '0;
      d1         <= '0;
      d2         <= '0;
    end else begin
      core_reset <= 1'b0;
      // abort beats every other transition out of a busy state
      if (abort && active) begin
        state      <= ST_ABORT;
        core_reset <= 1'b1;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (cmd_valid && cmd_ready) begin
              mid_q     <= midstate;
              tail_q    <= tail;
              target_q  <= target;
              cur_nonce <= nonce_start;
              // a count of 0 sweeps all 2^32 nonces
              remaining <= (nonce_count == '0) ?
                           {1'b1, 32'h0} :
                           {1'b0, nonce_count};
              state     <= ST_P1_RUN;
            end
          end
          ST_P1_RUN: begin
            if (core_done) begin
              d1    <= core_h_out;
              state <= ST_P1_GAP;
            end
          end
          ST_P1_GAP: state <= ST_P2_RUN;
          ST_P2_RUN: begin
            if (core_done) begin
              d2    <= core_h_out;
              state <= ST_P2_GAP;
            end
          end
          ST_P2_GAP: state <= ST_CHECK;
          ST_CHECK: begin
            if (hit || remaining == 33'd1) begin
              res_found <= hit;
              res_nonce <= cur_nonce;
              res_hash  <= hv;
              state     <= ST_REPORT;
            end else begin
              cur_nonce <= cur_nonce + 32'd1;
              remaining <= remaining - 33'd1;
              state     <= ST_P1_RUN;
            end
          end
          ST_ABORT: begin
            res_found <= 1'b0;
            res_nonce <= cur_nonce;
            res_hash  <= '0;
            state     <= ST_REPORT;
          end
          ST_REPORT: begin
            if (res_ready)
              state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sha2_nonce_sequencer.sv
// Bench for sha2_nonce_sequencer with a behavioural SHA-256 core
// and a byte-level double SHA-256 reference model.
module tb_sha2_nonce_sequencer;

  localparam logic [31:0] KT [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] IV_T = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [511:0] CHUNK1 = {
    32'h01000000, 256'h0,
    32'h3ba3edfd, 32'h7a7b12b2, 32'h7ac72c3e, 32'h67768f61,
    32'h7fc81bc3, 32'h888a5132, 32'h3a9fb8aa
  };

  localparam logic [255:0] TGT_GEN = 256'hFFFF << 208;
  localparam logic [255:0] GEN_HASH =
    256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;

  typedef logic [7:0] bq_t [$];

  logic         clk;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [255:0] midstate;
  logic [95:0]  tail;
  logic [31:0]  nonce_start;
  logic [31:0]  nonce_count;
  logic [255:0] target;
  logic         abort;
  logic         res_valid;
  logic         res_ready;
  logic         res_found;
  logic [31:0]  res_nonce;
  logic [255:0] res_hash;
  logic         core_reset;
  logic         core_start;
  logic [511:0] core_chunk;
  logic [255:0] core_h;
  logic [255:0] core_h_out = '0;
  logic         core_done = 1'b0;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;

  logic [255:0] gen_mid;
  logic [95:0]  gen_tail;

  sha2_nonce_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .midstate    (midstate),
    .tail        (tail),
    .nonce_start (nonce_start),
    .nonce_count (nonce_count),
    .target      (target),
    .abort       (abort),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_found   (res_found),
    .res_nonce   (res_nonce),
    .res_hash    (res_hash),
    .core_reset  (core_reset),
    .core_start  (core_start),
    .core_chunk  (core_chunk),
    .core_h      (core_h),
    .core_h_out  (core_h_out),
    .core_done   (core_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(
    input logic [31:0] x, input int n
  );
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(
    input logic [255:0] hin, input logic [511:0] blk
  );
    logic [31:0] w [0:63];
    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] s0, s1, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
      t1 = h + s1 + ((e & f) ^ (~e & g)) + KT[i] + w[i];
      s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
      t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b,
            hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e,  hin[95:64] + f,
            hin[63:32] + g,   hin[31:0] + h};
  endfunction

  // Full SHA-256 of a byte message, with standard padding
  function automatic logic [255:0] sha256_bytes(input bq_t msg);
    bq_t m;
    logic [63:0] bits;
    logic [255:0] h;
    logic [511:0] blk;
    m = msg;
    bits = 64'(msg.size()) * 64'd8;
    m.push_back(8'h80);
    while ((m.size() % 64) != 56) m.push_back(8'h00);
    for (int i = 7; i >= 0; i--) m.push_back(bits[8*i +: 8]);
    h = IV_T;
    for (int b = 0; b < m.size() / 64; b++) begin
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = m[64*b+j];
      h = sha_compress(h, blk);
    end
    return h;
  endfunction

  // Reference: build each 80-byte header, hash twice, reverse, compare
  task automatic model_job(
    input  logic [31:0]  st,
    input  logic [31:0]  cnt,
    input  logic [255:0] tg,
    output logic         f,
    output logic [31:0]  n,
    output logic [255:0] h,
    output int           tried
  );
    bq_t hdr;
    logic [511:0] c1;
    logic [255:0] dg, disp;
    logic [31:0] cur;
    c1 = CHUNK1;
    f = 1'b0; n = st; h = '0; tried = 0;
    for (longint k = 0; k < longint'(cnt); k++) begin
      cur = st + 32'(k);
      hdr = {};
      for (int j = 0; j < 64; j++) hdr.push_back(c1[511-8*j -: 8]);
      for (int j = 0; j < 12; j++) hdr.push_back(gen_tail[95-8*j -: 8]);
      for (int j = 0; j < 4; j++) hdr.push_back(cur[8*j +: 8]);
      dg = sha256_bytes(hdr);
      hdr = {};
      for (int j = 0; j < 32; j++) hdr.push_back(dg[255-8*j -: 8]);
      dg = sha256_bytes(hdr);
      for (int j = 0; j < 32; j++) disp[8*j +: 8] = dg[255-8*j -: 8];
      tried++;
      n = cur;
      h = disp;
      if (disp <= tg) begin
        f = 1'b1;
        break;
      end
    end
  endtask

  // Behavioural compression core: random latency, done held until start drops
  logic         m_busy = 1'b0;
  int           m_cnt = 0;
  logic [255:0] m_h;
  logic [511:0] m_c;

  always @(posedge clk) begin
    if (core_reset) begin
      m_busy    <= 1'b0;
      core_done <= 1'b0;
    end else if (core_done) begin
      if (!core_start) core_done <= 1'b0;
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        core_done  <= 1'b1;
        core_h_out <= sha_compress(m_h, m_c);
        m_busy     <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (core_start) begin
      m_busy    <= 1'b1;
      m_cnt     <= int'($urandom_range(1, 8));
      m_h       <= core_h;
      m_c       <= core_chunk;
      start_cnt <= start_cnt + 1;
    end
  end

  task automatic chk(
    input string tag, input logic [255:0] obs, input logic [255:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_job(
    input logic [31:0]  st,
    input logic [31:0]  cnt,
    input logic [255:0] tg,
    input int           hold,
    input bit           use_xh,
    input logic [255:0] xh,
    input string        tag
  );
    logic ef;
    logic [31:0] en;
    logic [255:0] eh;
    int tried, s0;
    bit busy_ok, seen, stab;
    logic sf;
    logic [31:0] sn;
    logic [255:0] sh;
    model_job(st, cnt, tg, ef, en, eh, tried);
    @(negedge clk);
    chk({tag, "_rdy"}, cmd_ready, 1);
    midstate = gen_mid; tail = gen_tail;
    nonce_start = st; nonce_count = cnt; target = tg;
    cmd_valid = 1'b1;
    s0 = start_cnt;
    @(negedge clk);
    cmd_valid = 1'b0;
    // scramble inputs: the job must run from latched copies
    midstate = {8{$urandom()}};
    tail = {3{$urandom()}};
    nonce_start = $urandom();
    target = {8{$urandom()}};
    busy_ok = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      if (res_valid === 1'b1) seen = 1'b1;
      else begin
        if (cmd_ready !== 1'b0) busy_ok = 1'b0;
        @(negedge clk);
      end
    end
    chk({tag, "_done"}, seen, 1);
    if (!seen) return;
    chk({tag, "_found"}, res_found, ef);
    chk({tag, "_nonce"}, res_nonce, en);
    chk({tag, "_hash"}, res_hash, eh);
    if (use_xh) chk({tag, "_known"}, res_hash, xh);
    chk({tag, "_starts"}, start_cnt - s0, 2 * tried);
    chk({tag, "_busy"}, busy_ok, 1);
    if (hold > 0) begin
      sf = res_found; sn = res_nonce; sh = res_hash;
      stab = 1'b1;
      nonce_start = 32'h1234; nonce_count = 1;
      cmd_valid = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (res_valid !== 1'b1 || res_found !== sf ||
            res_nonce !== sn || res_hash !== sh ||
            core_start !== 1'b0 || cmd_ready !== 1'b0)
          stab = 1'b0;
      end
      chk({tag, "_hold"}, stab, 1);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_idle"}, {res_valid, cmd_ready, core_start}, 3'b010);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    bit ok;
    logic [31:0] rs, rc;
    logic [255:0] rt;
    reset = 1'b1; cmd_valid = 1'b0; abort = 1'b0; res_ready = 1'b0;
    midstate = '0; tail = '0; nonce_start = '0;
    nonce_count = '0; target = '0;
    gen_mid = sha_compress(IV_T, CHUNK1);
    gen_tail = {32'h4b1e5e4a, 32'h29ab5f49, 32'hffff001d};

    @(negedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_found", res_found, 0);
    chk("rst_res_nonce", res_nonce, 0);
    chk("rst_res_hash", res_hash, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_reset", core_reset, 1);
    reset = 1'b0;
    #1 chk("rel_core_reset_hi", core_reset, 1);
    @(negedge clk);
    chk("rel_core_reset_lo", core_reset, 0);

    run_job(32'h7C2BAC1D, 1, TGT_GEN, 0, 1, GEN_HASH, "gen1");
    run_job(32'h7C2BAC1B, 4, TGT_GEN, 20, 1, GEN_HASH, "gen4");
    run_job(32'hFFFFFFFF, 2, '0, 0, 0, '0, "wrap");

    // abort in pass 2 of nonce 5 (sixth core start from nonce 3)
    @(negedge clk);
    midstate = gen_mid; tail = gen_tail;
    nonce_start = 32'd3; nonce_count = 32'd10; target = '0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    s0 = start_cnt;
    for (int i = 0; i < 1000 && (start_cnt - s0) < 6; i++)
      @(negedge clk);
    chk("ab_reach", start_cnt - s0, 6);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_core_reset", core_reset, 1);
    chk("ab_core_start", core_start, 0);
    @(negedge clk);
    chk("ab_core_reset_end", core_reset, 0);
    chk("ab_res_valid", res_valid, 1);
    chk("ab_res_found", res_found, 0);
    chk("ab_res_nonce", res_nonce, 5);
    chk("ab_res_hash", res_hash, 0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;

    run_job(32'h7C2BAC1D, 1, TGT_GEN, 0, 1, GEN_HASH, "post_ab");

    for (int r = 0; r < 3; r++) begin
      rs = $urandom();
      rc = $urandom_range(1, 3);
      rt = {32'($urandom()), {224{1'b1}}};
      run_job(rs, rc, rt, 0, 0, '0, $sformatf("rnd%0d", r));
    end

    // async reset while pass 1 is running
    @(negedge clk);
    midstate = gen_mid; tail = gen_tail;
    nonce_start = 32'd100; nonce_count = 32'd5; target = '0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    s0 = start_cnt;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (start_cnt != s0) ok = 1'b1;
      else @(negedge clk);
    end
    chk("ar_in_p1", core_start, 1);
    #1 reset = 1'b1;
    #1;
    chk("ar_cmd_ready", cmd_ready, 1);
    chk("ar_res_valid", res_valid, 0);
    chk("ar_res_nonce", res_nonce, 0);
    chk("ar_res_hash", res_hash, 0);
    chk("ar_core_start", core_start, 0);
    chk("ar_core_reset", core_reset, 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("ar_rel_core_reset", core_reset, 1);
    @(negedge clk);
    chk("ar_no_result", {res_valid, cmd_ready}, 2'b01);

    run_job(32'h7C2BAC1D, 1, TGT_GEN, 0, 1, GEN_HASH, "post_ar");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
